game_controller: RTL and testbench
==================================

# game_controller

Round/lives state machine that drives `screen_drawer` and the seven-segment timer path. Draws the two correct doors from a free-running LFSR, times each round and the inter-round pause, and judges player positions at timeout. Updates lives and declares game-over/winner. Replaces the hard-wired lives, door and `time_up`/`resume` logic in the top level; outputs connect directly to the `screen_drawer` ports of the same names.

## Interface
- `TICKS_PER_SEC`, default 25_000_000: `clk` cycles per second (the VGA clock).
- `ROUND_SECONDS`, default 10: play time per round, 1..15.
- `PAUSE_SECONDS`, default 1: pause after each judged round, ≥1.
- `START_LIVES`, default 3: lives per player at game start, 1..3.

- `clk` in 1: single clock, all state on its rising edge.
- `reset` in 1: asynchronous, active-low.
- `start` in 1: level, sampled each cycle. Starts a game from IDLE or OVER.
- `p1_pos`, `p2_pos` in 2: door each player stands at, 0..3.
- `correct_door_1`, `correct_door_2` out 2: winning door per player for the current round.
- `p1_lives`, `p2_lives` out 2: remaining lives, saturating at 0.
- `seconds` out 4: elapsed seconds in the current round, 0..ROUND_SECONDS.
- `time_up` out 1: high in JUDGE and PAUSE.
- `resume` out 1: one-cycle pulse on the first PLAY cycle after a PAUSE.
- `game_over` out 1: high in OVER.
- `winner` out 2: 01 = P1, 10 = P2, 11 = draw, 00 = none. Valid while `game_over` is high.

## Operation
- States: IDLE, PLAY, JUDGE, PAUSE, OVER.
- IDLE:
  - `start` → PLAY.
  - Lives load START_LIVES, `seconds` = 0, doors load from the LFSR.
- PLAY:
  - Tick counter counts 0..TICKS_PER_SEC-1. `seconds` increments on wrap.
  - When `seconds` reaches ROUND_SECONDS → JUDGE.
  - `start` is ignored.
- JUDGE, one cycle:
  - `pN_pos` is compared with `correct_door_N`. On mismatch, that player's lives decrement by 1, saturating at 0.
  - If either new lives value is 0 → OVER, else → PAUSE.
- PAUSE:
  - Lasts PAUSE_SECONDS·TICKS_PER_SEC cycles, then → PLAY.
  - On that transition: `seconds` ← 0, tick counter ← 0, doors reload from the LFSR, `resume` pulses.
- OVER:
  - `winner` is set from the final lives: P1 alive only → 01, P2 alive only → 10, both 0 → 11.
  - Outputs hold their values.
  - `start` → PLAY as a new game: lives reload, doors reload, `winner` clears to 00.
- LFSR:
  - 16-bit Fibonacci, taps x^16+x^14+x^13+x^11+1, seed 16'hACE1.
  - Steps every cycle in all states, never zero.
  - `correct_door_1` = lfsr[1:0], `correct_door_2` = lfsr[9:8], sampled at load.

## Timing
- Reset values:
  - state IDLE; lives = START_LIVES.
  - doors 00, seconds 0, time_up 0, resume 0, game_over 0, winner 00.
  - LFSR = seed; tick counter 0.
- `start` high in cycle n (IDLE/OVER) → state PLAY and new doors visible in cycle n+1.
- PLAY lasts exactly ROUND_SECONDS·TICKS_PER_SEC cycles. JUDGE follows for 1 cycle.
- Lives and `time_up` change registered. Lives are updated in the cycle after JUDGE; `time_up` rises in the JUDGE cycle.
- Positions are sampled only in the JUDGE cycle. Changes during PLAY have no effect.
- Reset mid-round aborts immediately to the reset values. No partial lives update.
- Both players at 1 life and both wrong → both 0 → OVER, winner 11.
- Width rules:
  - Tick counter width = $clog2(TICKS_PER_SEC).
  - Pause counter width = $clog2(PAUSE_SECONDS·TICKS_PER_SEC).
  - Lives decrement must not wrap below 0.

## Structure
- Package `game_pkg`:
  - `state_t` enum (IDLE, PLAY, JUDGE, PAUSE, OVER).
  - LFSR seed and tap constants.
  - `winner` encodings.
- Sub-module `lfsr16` (clk, reset, q[15:0]), free-running, seed from the package.
- Tick and pause counters live inline in `game_controller`.

## Test plan
All scenarios use TICKS_PER_SEC=4, ROUND_SECONDS=3, PAUSE_SECONDS=1, START_LIVES=3.

- Reset low then high, `start` pulse at cycle 10:
  - PLAY from cycle 11; `seconds` steps 0,1,2,3 every 4 cycles.
  - JUDGE at cycle 23; `time_up` high cycles 23–27.
  - `resume` single pulse at cycle 28 with new doors.
- Round 1, p1_pos = correct_door_1, p2_pos ≠ correct_door_2 → after JUDGE: p1_lives = 3, p2_lives = 2.
- P2 wrong for three rounds, P1 always right → p2_lives 2,1,0; `game_over` = 1, winner = 01; outputs frozen for 100 cycles.
- Both players at 1 life, both wrong → both lives 0, winner = 11, no PAUSE entered.
- Reset asserted mid-PAUSE → outputs return to reset values asynchronously; `start` afterwards begins from 3/3 lives.
- `start` held high through PLAY and PAUSE → no restart, round timing unchanged. In OVER, `start` → new game, lives 3/3, winner 00.

Source files
------------

// File: rtl/game_pkg.sv
// Shared types and constants for the round/lives game controller.
package game_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    PLAY  = 3'd1,
    JUDGE = 3'd2,
    PAUSE = 3'd3,
    OVER  = 3'd4
  } state_t;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // x^16+x^14+x^13+x^11+1 expressed as a right-shift tap mask on bits 0,2,3,5
  localparam logic [15:0] LFSR_TAPS = 16'h002D;

  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_P1   = 2'b01;
  localparam logic [1:0] WIN_P2   = 2'b10;
  localparam logic [1:0] WIN_DRAW = 2'b11;

  function automatic int clog2_min1(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic logic [1:0] final_winner(input logic [1:0] p1_lives,
                                              input logic [1:0] p2_lives);
    if (p1_lives != 2'd0 && p2_lives == 2'd0) return WIN_P1;
    if (p1_lives == 2'd0 && p2_lives != 2'd0) return WIN_P2;
    if (p1_lives == 2'd0 && p2_lives == 2'd0) return WIN_DRAW;
    return WIN_NONE;
  endfunction

endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit Fibonacci LFSR; the seed is non-zero so it never locks up.
module lfsr16
  import game_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  output logic [15:0] q
);

  logic [15:0] r_q;
  logic        w_fb;

  assign w_fb = ^(r_q & LFSR_TAPS);

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_q <= LFSR_SEED;
    else        r_q <= {w_fb, r_q[15:1]};
  end

  assign q = r_q;

endmodule

// File: rtl/game_controller.sv
// Round/lives state machine: draws doors, times rounds and pauses, judges positions,
// tracks lives and declares the winner.
module game_controller
  import game_pkg::*;
#(
  parameter int TICKS_PER_SEC = 25_000_000,
  parameter int ROUND_SECONDS = 10,
  parameter int PAUSE_SECONDS = 1,
  parameter int START_LIVES   = 3
)(
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [1:0] p1_pos,
  input  logic [1:0] p2_pos,
  output logic [1:0] correct_door_1,
  output logic [1:0] correct_door_2,
  output logic [1:0] p1_lives,
  output logic [1:0] p2_lives,
  output logic [3:0] seconds,
  output logic       time_up,
  output logic       resume,
  output logic       game_over,
  output logic [1:0] winner
);

  localparam int TICK_W       = clog2_min1(TICKS_PER_SEC);
  localparam int PAUSE_CYCLES = PAUSE_SECONDS * TICKS_PER_SEC;
  localparam int PAUSE_W      = clog2_min1(PAUSE_CYCLES);

  localparam logic [TICK_W-1:0]  TICK_MAX   = TICK_W'(TICKS_PER_SEC - 1);
  localparam logic [PAUSE_W-1:0] PAUSE_MAX  = PAUSE_W'(PAUSE_CYCLES - 1);
  localparam logic [3:0]         LAST_SEC   = 4'(ROUND_SECONDS - 1);
  localparam logic [1:0]         LIVES_INIT = 2'(START_LIVES);

  state_t              r_state;
  logic [TICK_W-1:0]   r_tick;
  logic [PAUSE_W-1:0]  r_pause;
  logic [3:0]          r_seconds;
  logic [1:0]          r_door1;
  logic [1:0]          r_door2;
  logic [1:0]          r_p1_lives;
  logic [1:0]          r_p2_lives;
  logic                r_time_up;
  logic                r_resume;
  logic                r_game_over;
  logic [1:0]          r_winner;

  logic [15:0] w_lfsr;
  logic [11:0] w_lfsr_unused;
  logic [1:0]  w_p1_lives_next;
  logic [1:0]  w_p2_lives_next;
  logic        w_any_dead;

  lfsr16 u_lfsr (
    .clk   (clk),
    .reset (reset),
    .q     (w_lfsr)
  );

  assign w_lfsr_unused = {w_lfsr[15:10], w_lfsr[7:2]};

  // Lives only ever drop by one per round and stop at zero.
  assign w_p1_lives_next = (p1_pos != r_door1 && r_p1_lives != 2'd0) ? r_p1_lives - 2'd1 : r_p1_lives;
  assign w_p2_lives_next = (p2_pos != r_door2 && r_p2_lives != 2'd0) ? r_p2_lives - 2'd1 : r_p2_lives;
  assign w_any_dead      = (w_p1_lives_next == 2'd0) || (w_p2_lives_next == 2'd0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_tick      <= '0;
      r_pause     <= '0;
      r_seconds   <= 4'd0;
      r_door1     <= 2'd0;
      r_door2     <= 2'd0;
      r_p1_lives  <= LIVES_INIT;
      r_p2_lives  <= LIVES_INIT;
      r_time_up   <= 1'b0;
      r_resume    <= 1'b0;
      r_game_over <= 1'b0;
      r_winner    <= WIN_NONE;
    end else begin
      r_resume <= 1'b0;
      case (r_state)
        IDLE, OVER: begin
          if (start) begin
            r_state     <= PLAY;
            r_tick      <= '0;
            r_seconds   <= 4'd0;
            r_door1     <= w_lfsr[1:0];
            r_door2     <= w_lfsr[9:8];
            r_p1_lives  <= LIVES_INIT;
            r_p2_lives  <= LIVES_INIT;
            r_game_over <= 1'b0;
            r_winner    <= WIN_NONE;
          end
        end
        PLAY: begin
          if (r_tick == TICK_MAX) begin
            r_tick    <= '0;
            r_seconds <= r_seconds + 4'd1;
            if (r_seconds == LAST_SEC) begin
              r_state   <= JUDGE;
              r_time_up <= 1'b1;
            end
          end else begin
            r_tick <= r_tick + TICK_W'(1);
          end
        end
        JUDGE: begin
          r_p1_lives <= w_p1_lives_next;
          r_p2_lives <= w_p2_lives_next;
          r_pause    <= '0;
          if (w_any_dead) begin
            r_state     <= OVER;
            r_time_up   <= 1'b0;
            r_game_over <= 1'b1;
            r_winner    <= final_winner(w_p1_lives_next, w_p2_lives_next);
          end else begin
            r_state <= PAUSE;
          end
        end
        PAUSE: begin
          if (r_pause == PAUSE_MAX) begin
            r_state   <= PLAY;
            r_time_up <= 1'b0;
            r_seconds <= 4'd0;
            r_tick    <= '0;
            r_door1   <= w_lfsr[1:0];
            r_door2   <= w_lfsr[9:8];
            r_resume  <= 1'b1;
          end else begin
            r_pause <= r_pause + PAUSE_W'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign correct_door_1 = r_door1;
  assign correct_door_2 = r_door2;
  assign p1_lives       = r_p1_lives;
  assign p2_lives       = r_p2_lives;
  assign seconds        = r_seconds;
  assign time_up        = r_time_up;
  assign resume         = r_resume;
  assign game_over      = r_game_over;
  assign winner         = r_winner;

endmodule

// File: tb/tb_game_controller.sv
// Randomised round-level bench for game_controller against a timeline/lives model.
module tb_game_controller;

  localparam int TPS = 4;
  localparam int RS  = 3;
  localparam int PS  = 1;
  localparam int SL  = 3;

  localparam int JUDGE_C   = RS * TPS;            // cycle index of JUDGE within a round
  localparam int PAUSE_END = JUDGE_C + PS * TPS;  // last PAUSE cycle

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic [1:0] p1_pos = 2'd0;
  logic [1:0] p2_pos = 2'd0;
  logic [1:0] correct_door_1, correct_door_2, p1_lives, p2_lives, winner;
  logic [3:0] seconds;
  logic       time_up, resume, game_over;

  int n_checks = 0;
  int n_pass   = 0;

  logic [15:0] m_lfsr;
  logic [1:0]  m_d1, m_d2;
  int          m_l1, m_l2;

  game_controller #(
    .TICKS_PER_SEC (TPS),
    .ROUND_SECONDS (RS),
    .PAUSE_SECONDS (PS),
    .START_LIVES   (SL)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .p1_pos         (p1_pos),
    .p2_pos         (p2_pos),
    .correct_door_1 (correct_door_1),
    .correct_door_2 (correct_door_2),
    .p1_lives       (p1_lives),
    .p2_lives       (p2_lives),
    .seconds        (seconds),
    .time_up        (time_up),
    .resume         (resume),
    .game_over      (game_over),
    .winner         (winner)
  );

  always #5 clk = ~clk;

  // Reference sequence x^16+x^14+x^13+x^11+1, advanced once per clock after reset.
  always @(posedge clk or negedge reset) begin
    if (!reset) m_lfsr <= 16'hACE1;
    else        m_lfsr <= {m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5], m_lfsr[15:1]};
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    else             n_pass++;
  endtask

  task automatic check_reset_values();
    check("rst_door1", correct_door_1, 0);
    check("rst_door2", correct_door_2, 0);
    check("rst_p1_lives", p1_lives, SL);
    check("rst_p2_lives", p2_lives, SL);
    check("rst_seconds", seconds, 0);
    check("rst_time_up", time_up, 0);
    check("rst_resume", resume, 0);
    check("rst_game_over", game_over, 0);
    check("rst_winner", winner, 0);
  endtask

  task automatic start_game(input bit hold);
    m_d1  = m_lfsr[1:0];
    m_d2  = m_lfsr[9:8];
    start = 1'b1;
    @(posedge clk); #1;
    if (!hold) start = 1'b0;
    m_l1 = SL;
    m_l2 = SL;
  endtask

  // Called on the first PLAY cycle of a round; walks the round cycle by cycle.
  task automatic run_round(input bit p1_ok, input bit p2_ok, input bit first,
                           input bit hold, input int stop_c, output bit over);
    int nl1, nl2, last;
    logic [1:0] exp_win;
    nl1  = p1_ok ? m_l1 : ((m_l1 > 0) ? m_l1 - 1 : 0);
    nl2  = p2_ok ? m_l2 : ((m_l2 > 0) ? m_l2 - 1 : 0);
    over = (nl1 == 0) || (nl2 == 0);
    if (!over)                      exp_win = 2'b00;
    else if (nl1 > 0)               exp_win = 2'b01;
    else if (nl2 > 0)               exp_win = 2'b10;
    else                            exp_win = 2'b11;
    last = over ? JUDGE_C + 1 : PAUSE_END;
    for (int c = 0; c <= last; c++) begin
      check("door1", correct_door_1, m_d1);
      check("door2", correct_door_2, m_d2);
      check("seconds", seconds, (c <= JUDGE_C) ? c / TPS : RS);
      check("time_up", time_up, (c >= JUDGE_C) && !(over && c > JUDGE_C));
      check("resume", resume, (c == 0) && !first);
      check("game_over", game_over, over && c > JUDGE_C);
      check("winner", winner, (over && c > JUDGE_C) ? exp_win : 2'b00);
      check("p1_lives", p1_lives, (c > JUDGE_C) ? nl1 : m_l1);
      check("p2_lives", p2_lives, (c > JUDGE_C) ? nl2 : m_l2);
      if (c == stop_c) begin
        if (c > JUDGE_C) begin m_l1 = nl1; m_l2 = nl2; end
        return;
      end
      if (c == last) begin
        if (!over) begin m_d1 = m_lfsr[1:0]; m_d2 = m_lfsr[9:8]; end
        break;
      end
      if (c == JUDGE_C) begin
        p1_pos = p1_ok ? m_d1 : m_d1 ^ 2'($urandom_range(1, 3));
        p2_pos = p2_ok ? m_d2 : m_d2 ^ 2'($urandom_range(1, 3));
      end else begin
        p1_pos = 2'($urandom);
        p2_pos = 2'($urandom);
      end
      start = (over && c >= JUDGE_C) ? 1'b0 : (hold ? 1'b1 : 1'($urandom_range(0, 1)));
      @(posedge clk); #1;
    end
    m_l1 = nl1;
    m_l2 = nl2;
    if (!over) begin @(posedge clk); #1; end
  endtask

  initial begin
    bit over;
    bit first;

    repeat (3) @(posedge clk);
    #1;
    check_reset_values();
    reset = 1'b1;
    repeat (9) @(posedge clk);
    #1;
    check("idle_p1_lives", p1_lives, SL);
    check("idle_time_up", time_up, 0);

    // Game 1: P1 always right, P2 always wrong -> P1 wins after three rounds.
    start_game(1'b0);
    first = 1'b1;
    over  = 1'b0;
    for (int r = 0; r < 3; r++) begin
      run_round(1'b1, 1'b0, first, 1'b0, -1, over);
      first = 1'b0;
    end
    check("g1_over", over, 1);
    for (int i = 0; i < 100; i++) begin
      p1_pos = 2'($urandom);
      p2_pos = 2'($urandom);
      start  = 1'b0;
      @(posedge clk); #1;
      check("frz_p1_lives", p1_lives, m_l1);
      check("frz_p2_lives", p2_lives, m_l2);
      check("frz_door1", correct_door_1, m_d1);
      check("frz_door2", correct_door_2, m_d2);
      check("frz_seconds", seconds, RS);
      check("frz_time_up", time_up, 0);
      check("frz_resume", resume, 0);
      check("frz_game_over", game_over, 1);
      check("frz_winner", winner, 2'b01);
    end

    // Game 2: start held through play and pause, both always wrong -> draw.
    start_game(1'b1);
    first = 1'b1;
    for (int r = 0; r < 3; r++) begin
      run_round(1'b0, 1'b0, first, 1'b1, -1, over);
      first = 1'b0;
    end
    check("g2_over", over, 1);

    // Game 3: random outcomes, bounded number of rounds.
    start_game(1'b0);
    first = 1'b1;
    over  = 1'b0;
    for (int r = 0; r < 8 && !over; r++) begin
      run_round($urandom_range(0, 2) != 0, $urandom_range(0, 2) != 0, first, 1'b0, -1, over);
      first = 1'b0;
    end

    // Reset in the middle of a pause.
    if (over) begin
      start_game(1'b0);
      first = 1'b1;
    end
    run_round(m_l1 <= 1, 1'b1, first, 1'b0, JUDGE_C + 2, over);
    reset = 1'b0;
    #1;
    check_reset_values();
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("post_rst_p1_lives", p1_lives, SL);
    check("post_rst_p2_lives", p2_lives, SL);
    start_game(1'b0);
    run_round($urandom_range(0, 1), $urandom_range(0, 1), 1'b1, 1'b0, -1, over);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
